fifo_read_drainer: RTL and testbench

- Read-side controller for the team's asynchronous FIFO. Lives entirely in the `rclk` domain.
- Watches `Empty` and issues `R_En` pops, then captures `R_Data` one cycle later into a small circular buffer.
- Presents words on a valid/ready stream with full 1-word/cycle throughput, with no combinational path from `Out_Ready` to `R_En`.
- Also keeps a popped-word counter for bring-up and self-checking benches.

---
 rtl/fifo_rd_pkg.sv | 31 +++
 rtl/fifo_read_drainer_skid_buf.sv | 104 ++++++++++
 rtl/fifo_read_drainer.sv | 105 ++++++++++
 tb/tb_fifo_read_drainer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
//
// Shared constants and sizing helpers for the asynchronous-FIFO read drainer.
//
// Contents:
//   DEF_DATAWIDTH - default FIFO / output word width
//   DEF_BUFDEPTH  - default number of local buffer entries (legal 3..16)
//   DEF_CNTWIDTH  - default width of the accepted-word counter
//   ptr_width()   - bits needed for a circular pointer over 'depth' entries
//   occ_width()   - bits needed to hold an occupancy of 0..depth inclusive
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_BUFDEPTH  = 4;
  localparam int DEF_CNTWIDTH  = 32;

  // Pointers index 0..depth-1. A depth of 1 would give $clog2 = 0, so the
  // result is floored at one bit to keep the vector declarations legal.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy must represent the value 'depth' itself (buffer full), hence
  // depth+1 distinct values.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : fifo_rd_pkg

// File: rtl/fifo_read_drainer_skid_buf.sv
// -----------------------------------------------------------------------------
// rd_skid_buf
//
// Small circular register buffer that sits between the FIFO read port and the
// output valid/ready stream. Pointers wrap at BUFDEPTH (which need not be a
// power of two). Reading is combinational from the head entry so a word is
// visible the cycle after it is written.
//
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset (pointers, occupancy, ovf)
//   push_i       in   write push_data_i at the tail this cycle
//   push_data_i  in   word to write
//   pop_i        in   retire the head entry this cycle (ignored when empty)
//   head_data_o  out  word at the head (don't-care when empty_o)
//   occ_o        out  number of valid entries, 0..BUFDEPTH
//   empty_o      out  occ_o == 0
//   ovf_o        out  sticky: a push arrived while full with no pop alongside
// -----------------------------------------------------------------------------
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter  int DATAWIDTH = DEF_DATAWIDTH,
  parameter  int BUFDEPTH  = DEF_BUFDEPTH,
  localparam int PTR_W     = ptr_width(BUFDEPTH),
  localparam int OCC_W     = occ_width(BUFDEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [DATAWIDTH-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [DATAWIDTH-1:0] head_data_o,
  output logic [OCC_W-1:0]     occ_o,
  output logic                 empty_o,
  output logic                 ovf_o
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUFDEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(BUFDEPTH);

  // Storage is not reset: after reset occupancy is zero, so stale contents
  // are never presented.
  logic [DATAWIDTH-1:0] mem_q [BUFDEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;

  logic full;
  logic do_write;
  logic do_read;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full    = (occ_q == FULL_OCC);
    empty_o = (occ_q == '0);

    do_read = pop_i & ~empty_o;
    // When full, a simultaneous pop frees the head slot, and that slot is
    // exactly where wptr points, so the write is still safe.
    do_write = push_i & (~full | do_read);

    ovf_d  = ovf_q | (push_i & full & ~do_read);
    wptr_d = do_write ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_read  ? ptr_inc(rptr_q) : rptr_q;

    occ_d = occ_q;
    unique case ({do_write, do_read})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_write) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[rptr_q];
  assign occ_o       = occ_q;
  assign ovf_o       = ovf_q;

endmodule : rd_skid_buf

// File: rtl/fifo_read_drainer.sv
// -----------------------------------------------------------------------------
// fifo_read_drainer
//
// Read-side controller for the asynchronous FIFO, entirely in the rclk domain.
// Pops the FIFO whenever it is non-empty, pops are enabled and there is room
// for the word (counting the one already in flight), captures R_Data one
// cycle after each pop into a small circular buffer and presents the buffer
// head on a valid/ready stream. Out_Ready only affects state through the
// buffer's registers, so there is no combinational path to R_En.
//
// Ports:
//   rclk       in   read-domain clock
//   rrst_n     in   synchronous active-low reset
//   Rd_Go      in   permits new FIFO pops while high
//   Empty      in   FIFO empty flag (synchronous to rclk)
//   R_Data     in   FIFO read data, valid one cycle after an R_En cycle
//   R_En       out  FIFO pop request
//   Out_Data   out  head-of-buffer word
//   Out_Valid  out  Out_Data holds a valid word
//   Out_Ready  in   consumer takes the word when Out_Valid & Out_Ready
//   Rd_Count   out  words accepted on the output since reset (wraps)
//   Ovf_Err    out  sticky: a capture arrived with the buffer full
// -----------------------------------------------------------------------------
module fifo_read_drainer
  import fifo_rd_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int BUFDEPTH  = DEF_BUFDEPTH,
  parameter int CNTWIDTH  = DEF_CNTWIDTH
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 Rd_Go,
  input  logic                 Empty,
  input  logic [DATAWIDTH-1:0] R_Data,
  output logic                 R_En,
  output logic [DATAWIDTH-1:0] Out_Data,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [CNTWIDTH-1:0]  Rd_Count,
  output logic                 Ovf_Err
);

  localparam int               OCC_W     = occ_width(BUFDEPTH);
  localparam logic [OCC_W:0]   DEPTH_LIM = (OCC_W + 1)'(BUFDEPTH);

  logic                 inflight_q, inflight_d;
  logic [CNTWIDTH-1:0]  rd_count_q, rd_count_d;

  logic [OCC_W-1:0]     buf_occ;
  logic                 buf_empty;
  logic                 buf_ovf;
  logic [DATAWIDTH-1:0] buf_head;
  logic                 buf_pop;

  // Slots already spoken for: words sitting in the buffer plus the one whose
  // data arrives next cycle. One extra bit so BUFDEPTH+1 cannot wrap.
  logic [OCC_W:0]       demand;

  always_comb begin
    demand = {1'b0, buf_occ} + {{OCC_W{1'b0}}, inflight_q};

    R_En = rrst_n & Rd_Go & ~Empty & (demand < DEPTH_LIM);

    // Gated by reset so the stream is quiet for the whole reset window,
    // including the very first cycle before any register has been cleared.
    Out_Valid = rrst_n & ~buf_empty;
    buf_pop   = Out_Valid & Out_Ready;

    inflight_d = R_En;
    rd_count_d = buf_pop ? rd_count_q + CNTWIDTH'(1) : rd_count_q;
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
    end
  end

  // The in-flight flag is the push strobe: R_Data belongs to the pop issued
  // in the previous cycle.
  rd_skid_buf #(
    .DATAWIDTH (DATAWIDTH),
    .BUFDEPTH  (BUFDEPTH)
  ) u_buf (
    .clk         (rclk),
    .rst_n       (rrst_n),
    .push_i      (inflight_q),
    .push_data_i (R_Data),
    .pop_i       (buf_pop),
    .head_data_o (buf_head),
    .occ_o       (buf_occ),
    .empty_o     (buf_empty),
    .ovf_o       (buf_ovf)
  );

  assign Out_Data = buf_head;
  assign Rd_Count = rd_count_q;
  assign Ovf_Err  = buf_ovf;

endmodule : fifo_read_drainer

// File: tb/tb_fifo_read_drainer.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_drainer
//
// Drives the drainer from a queue-based FIFO source and checks every cycle
// against a queue-based reference of the buffered stream. Scenario table for
// streaming / backpressure / Empty toggling, hand sequences for Rd_Go gating
// and mid-stream reset, then a randomized phase. CNTWIDTH is kept small so
// the counter wraps during the random phase.
// -----------------------------------------------------------------------------
module tb_fifo_read_drainer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 6;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          rd_go = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] r_data = '0;
  logic          r_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] rd_count;
  logic          ovf_err;

  fifo_read_drainer #(
    .DATAWIDTH (DW),
    .BUFDEPTH  (DEPTH),
    .CNTWIDTH  (CW)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .Rd_Go     (rd_go),
    .Empty     (empty),
    .R_Data    (r_data),
    .R_En      (r_en),
    .Out_Data  (out_data),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Rd_Count  (rd_count),
    .Ovf_Err   (ovf_err)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO source: words waiting in the asynchronous FIFO
  logic [DW-1:0] src_q[$];
  bit            force_empty = 1'b0;

  // Reference: words held by the drainer, pop-in-flight flag, accept count
  logic [DW-1:0] ref_q[$];
  bit            ref_inflight = 1'b0;
  logic [CW-1:0] ref_cnt = '0;

  // Observations since the last reset release
  int            cyc = 0;
  int            ren_pulses = 0;
  int            first_valid_cyc = -1;
  int            first_acc_cyc = -1;
  int            last_acc_cyc = -1;
  int            acc_total = 0;
  logic [DW-1:0] last_acc_data = '0;

  typedef struct {
    string name;
    int    nwords;
    int    stall;          // cycles of Out_Ready low after release
    bit    toggle;         // Empty forced high in alternate 2-cycle windows
    int    exp_count;
    int    exp_pulses;     // R_En pulses during the stall, -1 = not checked
    int    exp_first;      // cycle of first Out_Valid, -1 = not checked
    int    exp_span;       // last accept cycle - first accept cycle, -1 = skip
  } scen_t;

  scen_t tbl[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic load(input int n);
    src_q.delete();
    for (int i = 1; i <= n; i++) src_q.push_back(DW'(i));
  endtask

  // One clock cycle: compare at the falling edge, then advance the source
  // FIFO and the reference just after the rising edge.
  task automatic tick();
    bit exp_ren;
    bit exp_valid;
    bit ren_s;
    int occ_m;
    empty = force_empty || (src_q.size() == 0);
    @(negedge rclk);
    occ_m     = ref_q.size();
    exp_valid = rrst_n && (occ_m != 0);
    exp_ren   = rrst_n && rd_go && !empty && ((occ_m + (ref_inflight ? 1 : 0)) < DEPTH);
    chk("r_en", r_en, exp_ren);
    chk("out_valid", out_valid, exp_valid);
    if (exp_valid) chk("out_data", out_data, ref_q[0]);
    chk("rd_count", rd_count, ref_cnt);
    chk("ovf_err", ovf_err, 0);
    chk("r_en_while_empty", r_en & empty, 0);
    ren_s = r_en;
    if (rrst_n) begin
      if (r_en) ren_pulses++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (acc_total == 0) first_acc_cyc = cyc;
        last_acc_cyc  = cyc;
        acc_total++;
        last_acc_data = out_data;
        $display("xfer %0d: data=%0d cycle=%0d rd_count=%0d", acc_total, out_data, cyc, rd_count);
      end
    end
    @(posedge rclk);
    #1;
    if (!rrst_n) begin
      ref_q.delete();
      ref_inflight = 1'b0;
      ref_cnt = '0;
      cyc = 0;
      ren_pulses = 0;
      first_valid_cyc = -1;
      first_acc_cyc = -1;
      last_acc_cyc = -1;
      acc_total = 0;
    end else begin
      if (exp_valid && out_ready) begin
        void'(ref_q.pop_front());
        ref_cnt++;
      end
      if (ref_inflight) ref_q.push_back(r_data);
      ref_inflight = exp_ren;
      cyc++;
    end
    // R_Data carries the popped word for exactly one cycle; otherwise junk.
    if (ren_s && src_q.size() != 0) r_data = src_q.pop_front();
    else r_data = DW'($urandom);
  endtask

  task automatic do_reset(input int n);
    rrst_n = 1'b0;
    rd_go = 1'b1;
    out_ready = 1'b1;
    force_empty = 1'b0;
    repeat (n) tick();
    rrst_n = 1'b1;
    chk("reset_rd_count", rd_count, 0);
    chk("reset_ovf", ovf_err, 0);
  endtask

  initial begin
    int  k;
    bit  seen6;

    tbl[0] = '{"stream45",     45, 0,  1'b0, 45, -1, 2,  44};
    tbl[1] = '{"backpressure", 10, 20, 1'b0, 10, 4,  2,  -1};
    tbl[2] = '{"empty_toggle", 12, 0,  1'b1, 12, -1, -1, -1};

    // ---------------- table-driven scenarios ----------------
    for (int s = 0; s < 3; s++) begin
      load(tbl[s].nwords);
      do_reset(3);
      out_ready = (tbl[s].stall == 0);
      k = 0;
      while (acc_total < tbl[s].nwords && k < 400) begin
        if (tbl[s].stall > 0 && k == tbl[s].stall) begin
          chk({tbl[s].name, "_stall_pulses"}, ren_pulses, tbl[s].exp_pulses);
          chk({tbl[s].name, "_stall_head"}, out_data, 1);
          out_ready = 1'b1;
        end
        if (tbl[s].toggle) force_empty = ((k / 2) % 2) == 1;
        tick();
        k++;
      end
      force_empty = 1'b0;
      repeat (3) tick();
      chk({tbl[s].name, "_delivered"}, acc_total, tbl[s].nwords);
      chk({tbl[s].name, "_rd_count"}, rd_count, tbl[s].exp_count);
      chk({tbl[s].name, "_last_word"}, last_acc_data, tbl[s].nwords);
      chk({tbl[s].name, "_drained"}, out_valid, 0);
      if (tbl[s].exp_first >= 0) chk({tbl[s].name, "_first_valid"}, first_valid_cyc, tbl[s].exp_first);
      if (tbl[s].exp_span >= 0) chk({tbl[s].name, "_throughput"}, last_acc_cyc - first_acc_cyc, tbl[s].exp_span);
    end

    // ---------------- Rd_Go gating ----------------
    load(20);
    do_reset(2);
    k = 0;
    while (ren_pulses < 5 && k < 50) begin
      tick();
      k++;
    end
    rd_go = 1'b0;
    repeat (10) tick();
    chk("go_low_pulses", ren_pulses, 5);
    chk("go_low_count", rd_count, 5);
    chk("go_low_last", last_acc_data, 5);
    chk("go_low_drained", out_valid, 0);
    rd_go = 1'b1;
    seen6 = 1'b0;
    k = 0;
    while (acc_total < 20 && k < 100) begin
      tick();
      if (acc_total == 6 && !seen6) begin
        seen6 = 1'b1;
        chk("go_resume_word", last_acc_data, 6);
      end
      k++;
    end
    chk("go_resume_seen", seen6, 1);
    chk("go_final_count", rd_count, 20);

    // ---------------- reset mid-stream ----------------
    load(30);
    do_reset(2);
    k = 0;
    while (acc_total < 3 && k < 50) begin
      tick();
      k++;
    end
    out_ready = 1'b0;
    k = 0;
    while (!(ref_q.size() == 3 && ref_inflight) && k < 20) begin
      tick();
      k++;
    end
    chk("mid_pre_valid", out_valid, 1);
    rrst_n = 1'b0;
    tick();
    load(8);
    rrst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_post_valid", out_valid, 0);
    chk("mid_post_count", rd_count, 0);
    k = 0;
    while (acc_total < 8 && k < 60) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk("mid_delivered", acc_total, 8);
    chk("mid_rd_count", rd_count, 8);
    chk("mid_last_word", last_acc_data, 8);

    // ---------------- randomized ----------------
    src_q.delete();
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rrst_n = 1'b0;
        src_q.delete();
      end else begin
        rrst_n = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        for (int w = 0; w < int'($urandom_range(1, 3)); w++) src_q.push_back(DW'($urandom));
      end
      out_ready   = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 4) == 0);
      rd_go       = ($urandom_range(0, 9) != 0);
      tick();
    end
    rrst_n = 1'b1;
    rd_go = 1'b0;
    out_ready = 1'b1;
    force_empty = 1'b0;
    repeat (10) tick();
    chk("rand_drained", out_valid, 0);
    chk("rand_ovf", ovf_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fifo_read_drainer
